// File: rtl/tdc_evdma_pkg.sv
// Shared definitions for the TDC event-capture DMA: register map, FSM encoding,
// event word layout and counter widths.
package tdc_evdma_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_BASE   = 3'd1;
  localparam logic [2:0] REG_SIZE   = 3'd2;
  localparam logic [2:0] REG_WPTR   = 3'd3;
  localparam logic [2:0] REG_RPTR   = 3'd4;
  localparam logic [2:0] REG_LEVEL  = 3'd5;
  localparam logic [2:0] REG_OVF    = 3'd6;
  localparam logic [2:0] REG_THRESH = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam int WORD_W = 32;
  localparam int OVF_W  = 16;
  localparam int PTR_W  = 14;

  localparam logic [3:0] SIZE_RST = 4'd10;
  localparam logic [3:0] SIZE_MAX = 4'd14;

  // Channel index sits in the top bits of the event word, timestamp below it.
  function automatic int ch_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int ts_width_of(input int n);
    return WORD_W - $clog2(n);
  endfunction

  function automatic int ch_pos(input int n);
    return WORD_W - $clog2(n);
  endfunction

endpackage

// File: rtl/tdc_evdma_rr.sv
// nch-way round-robin arbiter; search starts one past the last granted channel.
module tdc_evdma_rr
  import tdc_evdma_pkg::*;
#(
  parameter int nch = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [nch-1:0] req,
  input  logic           advance,
  output logic [nch-1:0] grant
);

  localparam int CH_W = ch_width(nch);

  logic [CH_W-1:0] last;
  logic [CH_W-1:0] gidx;
  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    gidx  = last;
    idx   = last;
    found = 1'b0;
    // nch is a power of two, so the index wraps by truncation.
    for (int i = 1; i <= nch; i++) begin
      idx = last + CH_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= CH_W'(nch - 1);
    end else if (advance) begin
      last <= gidx;
    end
  end

endmodule

// File: rtl/tdc_evdma.sv
// TDC event-capture DMA: per-channel holding registers, round-robin onto a
// Wishbone master, ring buffer CSRs. TDCEVDMA_IRQ_EN enables THRESH and irq.
module tdc_evdma
  import tdc_evdma_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h2,
  parameter int         nch      = 2,
  parameter int         ts_width = 31
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [13:0]             csr_a,
  input  logic                    csr_we,
  input  logic [31:0]             csr_di,
  output logic [31:0]             csr_do,
  input  logic [nch-1:0]          detect_i,
  input  logic [nch*ts_width-1:0] ts_i,
  output logic [31:0]             wbm_adr_o,
  output logic [31:0]             wbm_dat_o,
  output logic [3:0]              wbm_sel_o,
  output logic [2:0]              wbm_cti_o,
  output logic                    wbm_we_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  output logic                    irq
);

  localparam int CH_W = ch_width(nch);

  state_t              state;
  logic                enable;
  logic [29:0]         base;
  logic [3:0]          size;
  logic [PTR_W-1:0]    wptr, rptr, mask, level;
  logic [OVF_W-1:0]    ovf, ovf_next;
  logic [OVF_W:0]      ovf_sum;
  logic                discard;
  logic [nch-1:0]      pending, grant, load, drop;
  logic [ts_width-1:0] ts_hold [nch];
  logic [CH_W-1:0]     gidx;
  logic [2:0]          ndrop;
  logic                sel, wr, clear, fire;
  logic [2:0]          ridx;
  logic [31:0]         rdata;
  logic                unused_bits;
`ifdef TDCEVDMA_IRQ_EN
  logic [31:0]         thresh;
`endif

  assign wbm_sel_o = 4'hf;
  assign wbm_cti_o = 3'b000;
  assign wbm_we_o  = 1'b1;
  assign unused_bits = ^{csr_a[9:3], csr_di};

  assign ridx  = csr_a[2:0];
  assign sel   = (csr_a[13:10] == csr_addr);
  assign wr    = sel && csr_we;
  // Reprogramming the ring geometry invalidates the pointers, so it clears too.
  assign clear = wr && (((ridx == REG_CTRL) && csr_di[1]) ||
                        (ridx == REG_BASE) || (ridx == REG_SIZE));

  assign mask  = PTR_W'((15'd1 << size) - 15'd1);
  assign level = (wptr - rptr) & mask;
  assign fire  = (state == ST_IDLE) && (|pending) && (level < mask) && !clear;

  tdc_evdma_rr #(.nch(nch)) u_rr (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .req     (pending),
    .advance (fire),
    .grant   (grant)
  );

  always_comb begin
    gidx  = '0;
    ndrop = '0;
    load  = '0;
    drop  = '0;
    for (int k = 0; k < nch; k++) begin
      if (grant[k]) gidx = CH_W'(k);
      load[k] = enable && detect_i[k] && (!pending[k] || (fire && grant[k]));
      drop[k] = enable && detect_i[k] && pending[k] && !(fire && grant[k]);
      if (drop[k]) ndrop = ndrop + 3'd1;
    end
    ovf_sum  = {1'b0, ovf} + (OVF_W + 1)'(ndrop);
    ovf_next = ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
  end

  always_comb begin
    rdata = '0;
    case (ridx)
      REG_CTRL:   rdata = {31'b0, enable};
      REG_BASE:   rdata = {base, 2'b00};
      REG_SIZE:   rdata = {28'b0, size};
      REG_WPTR:   rdata = {{(32-PTR_W){1'b0}}, wptr};
      REG_RPTR:   rdata = {{(32-PTR_W){1'b0}}, rptr};
      REG_LEVEL:  rdata = {{(32-PTR_W){1'b0}}, level};
      REG_OVF:    rdata = {{(32-OVF_W){1'b0}}, ovf};
`ifdef TDCEVDMA_IRQ_EN
      REG_THRESH: rdata = thresh;
`endif
      default:    rdata = '0;
    endcase
  end

`ifdef TDCEVDMA_IRQ_EN
  assign irq = ({{(32-PTR_W){1'b0}}, level} >= thresh) && (thresh != 32'd0);
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      enable    <= 1'b0;
      base      <= '0;
      size      <= SIZE_RST;
      wptr      <= '0;
      rptr      <= '0;
      ovf       <= '0;
      pending   <= '0;
      discard   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      csr_do    <= '0;
`ifdef TDCEVDMA_IRQ_EN
      thresh    <= '0;
`endif
    end else begin
      csr_do <= sel ? rdata : 32'd0;
      if (wr) begin
        case (ridx)
          REG_CTRL:   enable <= csr_di[0];
          REG_BASE:   base   <= csr_di[31:2];
          REG_SIZE:   size   <= (csr_di > 32'd14) ? SIZE_MAX : csr_di[3:0];
          REG_RPTR:   rptr   <= csr_di[PTR_W-1:0] & mask;
`ifdef TDCEVDMA_IRQ_EN
          REG_THRESH: thresh <= csr_di;
`endif
          default: ;
        endcase
      end

      ovf <= ovf_next;
      for (int k = 0; k < nch; k++) begin
        if (load[k])                pending[k] <= 1'b1;
        else if (fire && grant[k])  pending[k] <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fire) begin
            state     <= ST_WRITE;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wbm_ack_i) begin
            state     <= ST_IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            discard   <= 1'b0;
            if (!discard) wptr <= (wptr + PTR_W'(1)) & mask;
          end
        end
      endcase

      // An in-flight write finishes on the bus but its ack must not advance WPTR.
      if (clear) begin
        wptr    <= '0;
        rptr    <= '0;
        ovf     <= '0;
        pending <= '0;
        if ((state == ST_WRITE) && !wbm_ack_i) discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int k = 0; k < nch; k++) begin
      if (load[k]) ts_hold[k] <= ts_i[k*ts_width +: ts_width];
    end
    if (fire) begin
      wbm_adr_o <= {base, 2'b00} + {{(30-PTR_W){1'b0}}, wptr, 2'b00};
      wbm_dat_o <= {gidx, ts_hold[gidx]};
    end
  end

endmodule

// File: tb/tb_tdc_evdma.sv
// Directed self-checking bench for tdc_evdma (nch=2, ts_width=31).
module tb_tdc_evdma;

  localparam logic [3:0] BANK = 4'h2;
  localparam logic [2:0] R_CTRL = 3'd0, R_BASE = 3'd1, R_SIZE = 3'd2, R_WPTR = 3'd3;
  localparam logic [2:0] R_RPTR = 3'd4, R_LEVEL = 3'd5, R_OVF = 3'd6, R_THRESH = 3'd7;
`ifdef TDCEVDMA_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di, csr_do;
  logic [1:0]  detect_i;
  logic [61:0] ts_i;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;

  tdc_evdma #(.csr_addr(4'h2), .nch(2), .ts_width(31)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .detect_i  (detect_i),
    .ts_i      (ts_i),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] idx, input logic [31:0] val);
    @(negedge sys_clk);
    csr_a  = {BANK, 7'b0, idx};
    csr_di = val;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] bank, input logic [2:0] idx, output logic [31:0] val);
    @(negedge sys_clk);
    csr_a  = {bank, 7'b0, idx};
    csr_we = 1'b0;
    @(negedge sys_clk);
    val = csr_do;
  endtask

  task automatic fire_evt(input logic [1:0] m, input logic [30:0] t0, input logic [30:0] t1);
    @(negedge sys_clk);
    detect_i = m;
    ts_i     = {t1, t0};
    @(negedge sys_clk);
    detect_i = 2'b00;
  endtask

  task automatic wait_stb(output logic found);
    int n = 0;
    while (!wbm_stb_o && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    found = wbm_stb_o;
  endtask

  task automatic wb_expect(input string tag, input logic [31:0] adr, input logic [31:0] dat);
    logic found;
    wait_stb(found);
    chk({tag, "_stb"}, {31'b0, found}, 32'd1);
    if (found) begin
      chk({tag, "_adr"}, wbm_adr_o, adr);
      chk({tag, "_dat"}, wbm_dat_o, dat);
      wbm_ack_i = 1'b1;
      @(negedge sys_clk);
      wbm_ack_i = 1'b0;
    end
  endtask

  task automatic no_bus(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge sys_clk);
      if (wbm_cyc_o) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    detect_i = '0; ts_i = '0; wbm_ack_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Reset state
    chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_csr_do", csr_do, 32'd0);
    csr_rd(BANK, R_SIZE, rd);  chk("rst_size", rd, 32'd10);
    csr_rd(BANK, R_CTRL, rd);  chk("rst_ctrl", rd, 32'd0);
    csr_rd(BANK, R_WPTR, rd);  chk("rst_wptr", rd, 32'd0);
    csr_rd(4'h3, R_SIZE, rd);  chk("other_bank", rd, 32'd0);

    // Single event with latency check
    csr_wr(R_SIZE, 32'd4);
    csr_wr(R_BASE, 32'h4000_0000);
    csr_wr(R_CTRL, 32'd1);
    csr_rd(BANK, R_BASE, rd);  chk("base_rb", rd, 32'h4000_0000);
    fire_evt(2'b01, 31'h123, 31'h0);
    chk("lat_c1_stb", {31'b0, wbm_stb_o}, 32'd0);
    @(negedge sys_clk);
    chk("lat_c2_stb", {31'b0, wbm_stb_o}, 32'd1);
    chk("sel_const", {28'b0, wbm_sel_o}, 32'hf);
    chk("cti_we_const", {28'b0, wbm_cti_o, wbm_we_o}, 32'd1);
    wb_expect("single", 32'h4000_0000, 32'h0000_0123);
    csr_rd(BANK, R_WPTR, rd);  chk("single_wptr", rd, 32'd1);
    csr_rd(BANK, R_LEVEL, rd); chk("single_level", rd, 32'd1);

    // Round-robin: ch1 alone moves the pointer, then pairs start at ch0
    fire_evt(2'b10, 31'h0, 31'h77);
    wb_expect("rr_ch1", 32'h4000_0004, 32'h8000_0077);
    fire_evt(2'b11, 31'h5, 31'h6);
    wb_expect("rr_a0", 32'h4000_0008, 32'h0000_0005);
    wb_expect("rr_a1", 32'h4000_000C, 32'h8000_0006);
    fire_evt(2'b11, 31'h9, 31'hA);
    wb_expect("rr_b0", 32'h4000_0010, 32'h0000_0009);
    wb_expect("rr_b1", 32'h4000_0014, 32'h8000_000A);
    csr_rd(BANK, R_OVF, rd);   chk("rr_ovf", rd, 32'd0);
    csr_rd(BANK, R_WPTR, rd);  chk("rr_wptr", rd, 32'd6);

    // Full ring with SIZE=2
    csr_wr(R_SIZE, 32'd2);
    for (int i = 0; i < 3; i++) begin
      fire_evt(2'b01, 31'(i + 1), 31'h0);
      wb_expect($sformatf("full_w%0d", i), 32'h4000_0000 + 32'(4 * i), 32'(i + 1));
    end
    fire_evt(2'b01, 31'h4, 31'h0);
    no_bus("full_hold", 6);
    fire_evt(2'b01, 31'h5, 31'h0);
    csr_rd(BANK, R_OVF, rd);   chk("full_ovf", rd, 32'd1);
    csr_rd(BANK, R_LEVEL, rd); chk("full_level", rd, 32'd3);
    csr_rd(BANK, R_WPTR, rd);  chk("full_wptr", rd, 32'd3);
    csr_wr(R_RPTR, 32'd3);
    wb_expect("full_release", 32'h4000_000C, 32'h0000_0004);
    csr_rd(BANK, R_WPTR, rd);  chk("full_wptr_wrap", rd, 32'd0);

    // Wrap-around with RPTR in lockstep
    csr_wr(R_SIZE, 32'd2);
    for (int i = 0; i < 6; i++) begin
      fire_evt(2'b10, 31'h0, 31'(32'h10 + i));
      wb_expect($sformatf("wrap_%0d", i), 32'h4000_0000 + 32'(4 * (i % 4)), 32'h8000_0010 + 32'(i));
      csr_rd(BANK, R_WPTR, rd);
      chk($sformatf("wrap_wptr_%0d", i), rd, 32'((i + 1) % 4));
      csr_wr(R_RPTR, 32'((i + 1) % 4));
    end

    // Interrupt threshold
    csr_wr(R_SIZE, 32'd4);
    csr_wr(R_THRESH, 32'd2);
    csr_rd(BANK, R_THRESH, rd); chk("thresh_rb", rd, IRQ_ON ? 32'd2 : 32'd0);
    fire_evt(2'b01, 31'h1, 31'h0);
    wb_expect("irq_w0", 32'h4000_0000, 32'h1);
    chk("irq_lvl1", {31'b0, irq}, 32'd0);
    fire_evt(2'b01, 31'h2, 31'h0);
    wb_expect("irq_w1", 32'h4000_0004, 32'h2);
    chk("irq_lvl2", {31'b0, irq}, {31'b0, IRQ_ON});
    csr_wr(R_RPTR, 32'd2);
    chk("irq_fall", {31'b0, irq}, 32'd0);

    // CLEAR while a write is stalled
    fire_evt(2'b01, 31'h33, 31'h0);
    wait_stb(found);
    chk("clr_stb", {31'b0, found}, 32'd1);
    fire_evt(2'b01, 31'h34, 31'h0);
    fire_evt(2'b01, 31'h35, 31'h0);
    csr_rd(BANK, R_OVF, rd);   chk("clr_ovf_pre", rd, 32'd1);
    csr_wr(R_CTRL, 32'd3);
    chk("clr_cyc_held", {31'b0, wbm_cyc_o}, 32'd1);
    repeat (2) @(negedge sys_clk);
    wbm_ack_i = 1'b1;
    @(negedge sys_clk);
    wbm_ack_i = 1'b0;
    no_bus("clr_no_bus", 8);
    csr_rd(BANK, R_WPTR, rd);  chk("clr_wptr", rd, 32'd0);
    csr_rd(BANK, R_OVF, rd);   chk("clr_ovf", rd, 32'd0);
    csr_rd(BANK, R_CTRL, rd);  chk("clr_ctrl", rd, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
